// File: rtl/pzcorebus_error_slave.sv
// Error slave: accepts every command, drains write data, and answers each non-posted
// request with error responses (serror=1, sdata=0); READs get N RESPONSE_WITH_DATA beats.
module pzcorebus_error_slave #(
  parameter  int ID_WIDTH     = 8,
  parameter  int MAX_LENGTH   = 16,
  parameter  int DATA_WIDTH   = 64,
  parameter  int ADDR_WIDTH   = 32,
  parameter  int INFO_WIDTH   = 1,
  localparam int LENGTH_WIDTH = $clog2(MAX_LENGTH + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  // command channel
  input  logic                    i_mcmd_valid,
  output logic                    o_scmd_accept,
  input  logic [2:0]              i_mcmd,
  input  logic [ID_WIDTH-1:0]     i_mid,
  input  logic [ADDR_WIDTH-1:0]   i_maddr,
  input  logic [LENGTH_WIDTH-1:0] i_mlength,
  input  logic [INFO_WIDTH-1:0]   i_minfo,
  // write data channel
  input  logic                    i_mdata_valid,
  output logic                    o_sdata_accept,
  input  logic [DATA_WIDTH-1:0]   i_mdata,
  input  logic [DATA_WIDTH/8-1:0] i_mdata_byteen,
  input  logic                    i_mdata_last,
  // response channel
  output logic                    o_sresp_valid,
  input  logic                    i_mresp_accept,
  output logic [1:0]              o_sresp,
  output logic [ID_WIDTH-1:0]     o_sid,
  output logic                    o_serror,
  output logic [DATA_WIDTH-1:0]   o_sdata,
  output logic [INFO_WIDTH-1:0]   o_sinfo,
  output logic                    o_sresp_last
);

  // command / response encodings shared with the bus masters
  localparam logic [2:0] CMD_NULL             = 3'd0;
  localparam logic [2:0] CMD_READ             = 3'd1;
  localparam logic [2:0] CMD_WRITE            = 3'd2;
  localparam logic [2:0] CMD_WRITE_NON_POSTED = 3'd3;
  localparam logic [2:0] CMD_BROADCAST        = 3'd4;
  localparam logic [2:0] CMD_ATOMIC           = 3'd5;
  localparam logic [2:0] CMD_MESSAGE          = 3'd6;

  localparam logic [1:0] RESP_NULL               = 2'd0;
  localparam logic [1:0] RESP_RESPONSE           = 2'd1;
  localparam logic [1:0] RESP_RESPONSE_WITH_DATA = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t                  r_state;
  logic [2:0]              r_mcmd;
  logic [ID_WIDTH-1:0]     r_mid;
  logic [LENGTH_WIDTH-1:0] r_count;

  logic [LENGTH_WIDTH-1:0] w_beats;
  logic                    w_read;
  logic                    w_non_posted;
  logic                    w_last;
  logic                    w_respond;
  logic                    w_unused;

  assign w_beats      = (i_mlength == '0) ? LENGTH_WIDTH'(MAX_LENGTH) : i_mlength;
  assign w_read       = (r_mcmd == CMD_READ);
  assign w_non_posted = (r_mcmd == CMD_WRITE_NON_POSTED) || (r_mcmd == CMD_ATOMIC);
  // only READ bursts count beats; every other response is a single beat
  assign w_last       = !w_read || (r_count == '0);
  assign w_respond    = (r_state == RESPOND);
  assign w_unused     = &{1'b0, i_maddr, i_minfo, i_mdata, i_mdata_byteen};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_mcmd  <= CMD_NULL;
      r_mid   <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_mcmd_valid) begin
            r_mcmd  <= i_mcmd;
            r_mid   <= i_mid;
            r_count <= w_beats - LENGTH_WIDTH'(1);
            case (i_mcmd)
              CMD_READ:                 r_state <= RESPOND;
              CMD_WRITE, CMD_WRITE_NON_POSTED,
              CMD_BROADCAST, CMD_ATOMIC: r_state <= DRAIN;
              default:                  r_state <= IDLE;  // MESSAGE, NULL, unused codes
            endcase
          end
        end
        DRAIN: begin
          if (i_mdata_valid && i_mdata_last) begin
            r_state <= w_non_posted ? RESPOND : IDLE;
          end
        end
        RESPOND: begin
          if (i_mresp_accept) begin
            if (w_last) r_state <= IDLE;
            else        r_count <= r_count - LENGTH_WIDTH'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_scmd_accept  = (r_state == IDLE);
  assign o_sdata_accept = (r_state == DRAIN);
  assign o_sresp_valid  = w_respond;
  assign o_sresp        = !w_respond ? RESP_NULL :
                          w_read     ? RESP_RESPONSE_WITH_DATA : RESP_RESPONSE;
  assign o_sid          = w_respond ? r_mid : '0;
  assign o_serror       = w_respond;
  assign o_sdata        = '0;
  assign o_sinfo        = '0;
  assign o_sresp_last   = w_respond && w_last;

endmodule

// File: tb/tb_pzcorebus_error_slave.sv
// Bench for pzcorebus_error_slave: directed vector table, reset/backpressure sequences,
// and random transactions scored against a transaction-level expectation model.
module tb_pzcorebus_error_slave;
  localparam int IDW  = 8;
  localparam int MAXL = 16;
  localparam int DW   = 64;
  localparam int LW   = $clog2(MAXL + 1);

  localparam logic [2:0] C_NULL = 3'd0, C_READ = 3'd1, C_WRITE = 3'd2, C_WNP = 3'd3,
                         C_BC = 3'd4, C_ATOM = 3'd5, C_MSG = 3'd6;
  localparam logic [1:0] R_NULL = 2'd0, R_RESP = 2'd1, R_RWD = 2'd2;

  logic            clk = 1'b0, rst_n = 1'b0;
  logic            mcmd_valid = 1'b0, scmd_accept;
  logic [2:0]      mcmd = '0;
  logic [IDW-1:0]  mid = '0;
  logic [31:0]     maddr = '0;
  logic [LW-1:0]   mlength = '0;
  logic [0:0]      minfo = '0;
  logic            mdata_valid = 1'b0, sdata_accept, mdata_last = 1'b0;
  logic [DW-1:0]   mdata = '0;
  logic [DW/8-1:0] mdata_byteen = '1;
  logic            sresp_valid, mresp_accept = 1'b0, serror, sresp_last;
  logic [1:0]      sresp;
  logic [IDW-1:0]  sid;
  logic [DW-1:0]   sdata;
  logic [0:0]      sinfo;

  pzcorebus_error_slave #(.ID_WIDTH(IDW), .MAX_LENGTH(MAXL), .DATA_WIDTH(DW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_mcmd_valid(mcmd_valid), .o_scmd_accept(scmd_accept), .i_mcmd(mcmd), .i_mid(mid),
    .i_maddr(maddr), .i_mlength(mlength), .i_minfo(minfo),
    .i_mdata_valid(mdata_valid), .o_sdata_accept(sdata_accept), .i_mdata(mdata),
    .i_mdata_byteen(mdata_byteen), .i_mdata_last(mdata_last),
    .o_sresp_valid(sresp_valid), .i_mresp_accept(mresp_accept), .o_sresp(sresp),
    .o_sid(sid), .o_serror(serror), .o_sdata(sdata), .o_sinfo(sinfo),
    .o_sresp_last(sresp_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // transaction-level model: what the bus should see for a given command
  function automatic int model_beats(input logic [2:0] cmd, input logic [LW-1:0] len);
    if (cmd == C_READ) return (len == 0) ? MAXL : int'(len);
    if (cmd == C_WNP || cmd == C_ATOM) return 1;
    return 0;
  endfunction

  function automatic logic [1:0] model_resp(input logic [2:0] cmd);
    return (cmd == C_READ) ? R_RWD : R_RESP;
  endfunction

  function automatic bit model_busy(input logic [2:0] cmd);
    return cmd inside {C_READ, C_WRITE, C_WNP, C_BC, C_ATOM};
  endfunction

  // one complete transaction; entered and left at posedge+1 with the slave idle
  task automatic run_txn(input string name, input logic [2:0] cmd, input logic [IDW-1:0] id,
                         input logic [LW-1:0] len, input int ndata, input int stall0,
                         input bit rnd, input int exp_beats, input logic [1:0] exp_resp);
    int beats, n_last, last_idx, bad_field, bad_idle, unstable, stalls, lat, cyc, guard;
    bit prev_st, acc, tmo;
    logic [11:0] saved;
    beats = 0; n_last = 0; last_idx = -1; bad_field = 0; bad_idle = 0; unstable = 0;
    stalls = 0; lat = -1; cyc = 0; prev_st = 0; tmo = 0; saved = '0;

    chk({name, ".cmd_ready"}, scmd_accept, 1);
    mcmd_valid = 1'b1; mcmd = cmd; mid = id; mlength = len; maddr = $urandom;
    @(posedge clk); #1;
    mcmd_valid = 1'b0;
    chk({name, ".accept_after_take"}, scmd_accept, model_busy(cmd) ? 0 : 1);

    for (int d = 0; d < ndata && !tmo; d++) begin
      if (rnd && $urandom_range(0, 2) == 0) begin
        mdata_valid = 1'b0;
        @(posedge clk); #1;
      end
      mdata_valid = 1'b1; mdata_last = (d == ndata - 1); mdata = {$urandom, $urandom};
      guard = 0;
      while (!sdata_accept && guard < 50) begin
        if (sresp_valid) bad_idle++;
        @(posedge clk); #1;
        guard++;
      end
      if (guard >= 50) tmo = 1;
      else begin
        if (sresp_valid) bad_idle++;
        @(posedge clk); #1;
      end
    end
    mdata_valid = 1'b0; mdata_last = 1'b0;

    while (!scmd_accept && cyc < 400) begin
      if (sresp_valid) begin
        if (lat < 0) lat = cyc;
        if (prev_st && {sresp, sid, serror, sresp_last} !== saved) unstable++;
        if (sresp !== exp_resp || sid !== id || serror !== 1'b1 || sdata !== '0) bad_field++;
        acc = (stalls < stall0) ? 1'b0 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
        mresp_accept = acc;
        if (!acc) begin
          stalls++; prev_st = 1; saved = {sresp, sid, serror, sresp_last};
        end else begin
          prev_st = 0;
          if (sresp_last) begin n_last++; last_idx = beats; end
          beats++;
        end
      end else begin
        if (sresp !== R_NULL || sid !== '0 || serror !== 1'b0 || sresp_last !== 1'b0) bad_idle++;
        mresp_accept = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    mresp_accept = 1'b0;
    if (sresp_valid || serror || sresp_last || sresp !== R_NULL) bad_idle++;

    chk({name, ".no_timeout"}, (tmo || cyc >= 400) ? 1 : 0, 0);
    chk({name, ".beats"}, beats, exp_beats);
    chk({name, ".last_count"}, n_last, (exp_beats > 0) ? 1 : 0);
    if (beats > 0) chk({name, ".last_on_final"}, last_idx, beats - 1);
    chk({name, ".resp_fields"}, bad_field, 0);
    chk({name, ".idle_fields"}, bad_idle, 0);
    chk({name, ".stable_stall"}, unstable, 0);
    if (cmd == C_READ) chk({name, ".read_latency"}, lat, 0);
    if (!rnd) chk({name, ".stall_cycles"}, stalls, (exp_beats > 0) ? stall0 : 0);
  endtask

  typedef struct {
    logic [2:0]    cmd;
    logic [IDW-1:0] id;
    logic [LW-1:0] len;
    int            ndata;
    int            stall0;
    int            exp_beats;
    logic [1:0]    exp_resp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int seen_v, seen_a, beats, guard;
    logic [2:0]    rc;
    logic [LW-1:0] rl;

    vecs[0] = '{C_READ,  8'h12, 5'd4,  0, 0, 4,  R_RWD};
    vecs[1] = '{C_WRITE, 8'h33, 5'd3,  3, 0, 0,  R_NULL};
    vecs[2] = '{C_WNP,   8'h05, 5'd2,  2, 5, 1,  R_RESP};
    vecs[3] = '{C_READ,  8'h40, 5'd0,  0, 0, 16, R_RWD};
    vecs[4] = '{C_MSG,   8'h77, 5'd1,  0, 0, 0,  R_NULL};
    vecs[5] = '{C_READ,  8'h21, 5'd1,  0, 0, 1,  R_RWD};
    vecs[6] = '{C_ATOM,  8'h09, 5'd1,  1, 2, 1,  R_RESP};
    vecs[7] = '{C_BC,    8'h0a, 5'd2,  5, 0, 0,  R_NULL};
    vecs[8] = '{C_NULL,  8'h01, 5'd3,  0, 0, 0,  R_NULL};
    vecs[9] = '{C_READ,  8'hff, 5'd16, 0, 3, 16, R_RWD};

    // asynchronous reset values, before any clock edge
    #2;
    chk("reset.scmd_accept", scmd_accept, 1);
    chk("reset.sdata_accept", sdata_accept, 0);
    chk("reset.sresp_valid", sresp_valid, 0);
    chk("reset.serror", serror, 0);
    chk("reset.sresp_last", sresp_last, 0);
    chk("reset.sid", sid, 0);
    chk("reset.sresp", sresp, R_NULL);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // vecs 4 and 5 run back to back: MESSAGE then READ on the following cycle
    for (int i = 0; i < 10; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].id, vecs[i].len, vecs[i].ndata,
              vecs[i].stall0, 1'b0, vecs[i].exp_beats, vecs[i].exp_resp);

    // reset during the second beat of a 4-beat READ
    mcmd_valid = 1'b1; mcmd = C_READ; mid = 8'h3c; mlength = 5'd4; mresp_accept = 1'b1;
    @(posedge clk); #1;
    mcmd_valid = 1'b0;
    chk("rst_read.beat1_valid", sresp_valid, 1);
    @(posedge clk); #1;
    chk("rst_read.beat2_valid", sresp_valid, 1);
    rst_n = 1'b0; #1;
    chk("rst_read.valid_drop", sresp_valid, 0);
    chk("rst_read.cmd_ready", scmd_accept, 1);
    chk("rst_read.last_low", sresp_last, 0);
    chk("rst_read.error_low", serror, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen_v = 0;
    repeat (6) begin
      if (sresp_valid || !scmd_accept) seen_v++;
      @(posedge clk); #1;
    end
    mresp_accept = 1'b0;
    chk("rst_read.no_beats_after", seen_v, 0);

    // reset mid-DRAIN, then data offered while idle must stay unaccepted
    mcmd_valid = 1'b1; mcmd = C_WNP; mid = 8'h44; mlength = 5'd2;
    @(posedge clk); #1;
    mcmd_valid = 1'b0; mdata_valid = 1'b1; mdata_last = 1'b0;
    chk("rst_drain.in_drain", sdata_accept, 1);
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    chk("rst_drain.accept_drop", sdata_accept, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; mdata_last = 1'b1;
    seen_v = 0; seen_a = 0;
    repeat (4) begin
      if (sdata_accept) seen_a++;
      if (sresp_valid) seen_v++;
      @(posedge clk); #1;
    end
    chk("idle_data.not_accepted", seen_a, 0);
    chk("rst_drain.no_response", seen_v, 0);

    // data offered during RESPOND stays unaccepted
    mcmd_valid = 1'b1; mcmd = C_READ; mid = 8'h55; mlength = 5'd2;
    @(posedge clk); #1;
    mcmd_valid = 1'b0; seen_a = 0;
    repeat (3) begin
      if (sdata_accept || !sresp_valid) seen_a++;
      @(posedge clk); #1;
    end
    chk("respond_data.not_accepted", seen_a, 0);
    mdata_valid = 1'b0; mdata_last = 1'b0; mresp_accept = 1'b1;
    beats = 0; guard = 0;
    while (!scmd_accept && guard < 20) begin
      if (sresp_valid) beats++;
      @(posedge clk); #1;
      guard++;
    end
    mresp_accept = 1'b0;
    chk("respond_data.beats", beats, 2);

    // random transactions against the model
    for (int i = 0; i < 40; i++) begin
      rc = 3'($urandom_range(0, 6));
      rl = LW'($urandom_range(0, MAXL));
      run_txn($sformatf("rnd%0d", i), rc, IDW'($urandom), rl,
              (rc inside {C_WRITE, C_WNP, C_BC, C_ATOM}) ? $urandom_range(1, 4) : 0,
              $urandom_range(0, 2), 1'b1, model_beats(rc, rl), model_resp(rc));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pzcorebus_error_slave.md
PZCOREBUS_ERROR_SLAVE -- requirements
Module: pzcorebus_error_slave

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 8, width of mid/sid.
REQ-002 SHALL have parameter MAX_LENGTH, default 16, maximum burst length in data beats; mlength of 0 encodes MAX_LENGTH.
REQ-003 SHALL have parameter DATA_WIDTH, default 64, width of sdata; LENGTH_WIDTH = clog2(MAX_LENGTH+1) derived.
REQ-004 SHALL have port i_clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port i_rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have slave_if.mcmd_valid input 1; scmd_accept output 1; mcmd input command-type; mid input ID_WIDTH; mlength input LENGTH_WIDTH; maddr/minfo inputs, ignored.
REQ-007 SHALL have slave_if.mdata_valid input 1; sdata_accept output 1; mdata_last input 1; mdata/mdata_byteen inputs, ignored.
REQ-008 SHALL have slave_if.sresp_valid output 1; mresp_accept input 1; sresp output response-type; sid output ID_WIDTH; serror output 1; sdata output DATA_WIDTH; sresp_last output 1; sinfo output, driven 0.

Function
REQ-009 SHALL implement FSM with states IDLE, DRAIN, RESPOND; all outputs driven from registers or state only, never combinationally from inputs.
REQ-010 scmd_accept SHALL be 1 exactly when state is IDLE; a command is taken when mcmd_valid and scmd_accept are both 1.
REQ-011 On take, SHALL capture mcmd, mid and beat count N (mlength, 0 -> MAX_LENGTH).
REQ-012 IDLE transitions: WRITE, WRITE_NON_POSTED, BROADCAST, ATOMIC -> DRAIN; READ -> RESPOND; MESSAGE, NULL -> stay IDLE (no response).
REQ-013 sdata_accept SHALL be 1 exactly when state is DRAIN; every mdata_valid beat is consumed, contents discarded.
REQ-014 DRAIN SHALL exit on consumed beat with mdata_last=1: WRITE/BROADCAST -> IDLE; WRITE_NON_POSTED/ATOMIC -> RESPOND. Beat count is not checked against mlength.
REQ-015 In RESPOND, sresp_valid SHALL be 1; sid = captured mid; serror = 1; sdata = 0.
REQ-016 READ response: sresp = RESPONSE_WITH_DATA, exactly N beats, sresp_last = 1 only on beat N; 1 to MAX_LENGTH inclusive.
REQ-017 Non-READ response: sresp = RESPONSE, single beat, sresp_last = 1.
REQ-018 A beat completes only when sresp_valid and mresp_accept are both 1; sresp/sid/serror/sresp_last SHALL hold stable while unaccepted.
REQ-019 Beat counter SHALL be LENGTH_WIDTH bits, loaded with N-1, decremented per completed beat; no wrap; RESPOND -> IDLE on completion of last beat.
REQ-020 Back-to-back: earliest next command take is the cycle after the last response beat completes; minimum command-to-first-response latency is 1 cycle (READ).
REQ-021 Outside RESPOND, sresp SHALL be NULL, sresp_valid 0, sid 0, serror 0, sresp_last 0.
REQ-022 mdata_valid arriving in IDLE or RESPOND SHALL be left unaccepted (sdata_accept 0) until DRAIN.

Reset
REQ-023 On i_rst_n low, asynchronously: state IDLE, counter 0, captured mcmd NULL, captured mid 0; hence scmd_accept 1 and sdata_accept, sresp_valid, serror, sresp_last 0 immediately.
REQ-024 Reset mid-DRAIN or mid-RESPOND SHALL abandon the transaction; no response beat issued after reset release for it.

Verification
REQ-025 READ mid=0x12 mlength=4, mresp_accept=1 -> scmd_accept drops next cycle; 4 RESPONSE_WITH_DATA beats, sid=0x12, serror=1, sresp_last on 4th only; scmd_accept 1 the cycle after.
REQ-026 WRITE mlength=3 with 3 data beats -> 3 beats accepted, no sresp_valid ever, back to IDLE after mdata_last.
REQ-027 WRITE_NON_POSTED mid=0x5 with 2 data beats, mresp_accept held 0 for 5 cycles -> one RESPONSE beat, sid=0x5, serror=1, sresp_last=1, fields stable for all 5 stalled cycles.
REQ-028 READ mlength=0, MAX_LENGTH=16 -> exactly 16 response beats, last flagged.
REQ-029 i_rst_n asserted during 2nd of 4 READ beats -> sresp_valid 0 in same cycle, scmd_accept 1, no further beats after release.
REQ-030 MESSAGE command then immediate READ mlength=1 -> MESSAGE taken with no response; READ taken next cycle, single beat with sresp_last=1.
